dram_port_master: RTL and testbench
===================================

Name: dram_port_master

Overview:
- Per-core initiator for one port of the shared 4-port DRAM.
- Accepts single or burst load/store requests from the core over a valid/ready handshake.
- Drives the DRAM port signals `write_en`, `addr` and `data_in`, and captures the DRAM's registered `data_out` one cycle after the address.
- Returns read data to the core as a response stream. One instance sits between each core and its DRAM port.

Parameters:
- DATA_W, 16, data word width; matches the DRAM word.
- ADDR_W, 16, address width; matches the DRAM port.
- LEN_W, 4, width of the burst length field. A burst is req_len+1 beats, max 16.
- MEM_DEPTH, 1025, number of valid DRAM words. Used only by the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store burst, 0 = load burst
- req_addr  in  ADDR_W  first word address of the burst
- req_len  in  LEN_W  beats minus 1
- wdata_valid  in  1  store data beat valid
- wdata_ready  out  1  controller accepts a store beat
- wdata  in  DATA_W  store data
- resp_valid  out  1  load data valid; no backpressure, the core must take it
- resp_last  out  1  final beat of the load burst
- resp_rdata  out  DATA_W  load data
- wr_done  out  1  one-cycle pulse: last store beat issued to the DRAM
- addr_err  out  1  one-cycle pulse: request rejected. Tied 0 unless the optional feature is compiled in.
- mem_write_en  out  1  to DRAM `write_en`
- mem_addr  out  ADDR_W  to DRAM `addr`
- mem_data_in  out  DATA_W  to DRAM `data_in`
- mem_data_out  in  DATA_W  from DRAM `data_out`, registered in the DRAM: valid the cycle after the address when `write_en`=0

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, req_ready=0 while rst_n is low.
  - wdata_ready, resp_valid, resp_last, wr_done, addr_err, mem_write_en = 0.
  - mem_addr, mem_data_in, resp_rdata = 0.
  - req_ready=1 in the first cycle after release.
- FSM states:
  - IDLE: req_ready=1.
  - RD: issuing load addresses.
  - RD_WAIT: draining the 2-deep read pipeline.
  - WR: accepting store beats.
  - WR_END: wr_done cycle.
- Acceptance: req_valid && req_ready in cycle 0. req_addr, req_len and req_write are latched; req_ready=0 from cycle 1.
- Load of N=req_len+1 beats:
  - Cycles 1..N: mem_write_en=0, mem_addr=A+i.
  - Cycles 3..N+2: resp_valid=1, resp_rdata=ram[A+i], back-to-back.
  - resp_last=1 in cycle N+2. The FSM is in RD_WAIT after the last address.
  - IDLE (req_ready=1) in cycle N+3.
- Store:
  - From cycle 1, state WR and wdata_ready=1 until the last beat is accepted, then 0.
  - Beat i accepted in cycle k (wdata_valid && wdata_ready) gives, in cycle k+1: mem_write_en=1, mem_addr=A+i, mem_data_in=wdata.
  - A cycle with no accepted beat gives mem_write_en=0 in the following cycle. This is a stall; no address advance.
  - wr_done=1 in the same cycle as the last mem_write_en. IDLE in the cycle after that.
- Idle: mem_write_en=0. mem_addr and mem_data_in hold their last values. DRAM data_out is ignored except when a captured beat is expected.
- Address arithmetic: A+i is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
- Ordering: a load accepted after wr_done always observes the stored data. The earliest load address cycle falls after the DRAM write edge.
- Reset mid-burst: the FSM aborts to IDLE. In-flight read data is discarded, with no resp_valid after reset. A partially written burst is not rolled back.
- wdata beats presented outside WR are ignored (wdata_ready=0).

Optional Feature:
- Macro: ADDR_BOUND_CHECK_EN.
- Defined:
  - At acceptance, compute req_addr+req_len at ADDR_W+1 bits, with no wrap.
  - If the result > MEM_DEPTH-1, the request is rejected: addr_err=1 in cycle 1, no mem_write_en, no resp_valid, no wdata consumed.
  - req_ready=1 in cycle 2.
- Undefined: addr_err is constant 0 and addresses wrap as above.

Test Plan:
1. rst_n=0 for 3 cycles with req_valid=1 → req_ready=0, mem_write_en=0, resp_valid=0. After release, req_ready=1 on the first cycle.
2. Store A=0x0010, len=0, wdata=0x0055 → exactly one cycle with mem_write_en=1, mem_addr=0x0010, mem_data_in=0x0055, with wr_done in the same cycle. Then load 0x0010 → resp_rdata=0x0055 with resp_last=1, 3 cycles after acceptance.
3. Store burst A=0x0020, len=3, data 0x00A0..0x00A3, wdata_valid low for one cycle after beat 1 → mem_write_en pattern 1,1,0,1,1. Then load burst len=3 → 4 consecutive responses 0x00A0..0x00A3 in cycles 3–6, resp_last on the 4th.
4. Load A=0xFFFE, len=3, macro undefined → mem_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001 in cycles 1–4.
5. rst_n pulsed low in cycle 2 of a len=7 load → no resp_valid after reset, req_ready=1 the cycle after release.
6. ADDR_BOUND_CHECK_EN defined, store A=0x03FE, len=3 → addr_err pulse in cycle 1, wdata_ready never 1, mem_write_en stays 0, req_ready=1 in cycle 2.

Source files
------------

// File: rtl/dram_port_master.sv
// Per-core initiator for one port of the shared DRAM: valid/ready load/store bursts in, DRAM port out.
// Optional define ADDR_BOUND_CHECK_EN rejects bursts that would run past word MEM_DEPTH-1.
module dram_port_master #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 4,
  parameter int MEM_DEPTH = 1025
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic              resp_last,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              wr_done,
  output logic              addr_err,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_END} state_t;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              vld_p1;
  logic              last_p1;
  logic              accept;
  logic              wbeat;
  logic              bound_err;

  assign accept = req_valid && req_ready;
  assign wbeat  = wdata_valid && wdata_ready;

`ifdef ADDR_BOUND_CHECK_EN
  logic [ADDR_W:0] end_addr;
  // One extra bit so a burst crossing the top of the address space is caught, not wrapped.
  assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign bound_err = end_addr > (ADDR_W+1)'(MEM_DEPTH - 1);
`else
  assign bound_err = 1'b0;
`endif

  // Burst bookkeeping: remaining beats and next store address.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      cnt     <= req_len;
      wr_addr <= req_addr;
    end else if (state == RD && cnt != '0) begin
      cnt <= cnt - LEN_W'(1);
    end else if (state == WR && wbeat) begin
      wr_addr <= wr_addr + ADDR_W'(1);
      if (cnt != '0) cnt <= cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      wdata_ready  <= 1'b0;
      resp_valid   <= 1'b0;
      resp_last    <= 1'b0;
      wr_done      <= 1'b0;
      addr_err     <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      resp_rdata   <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
    end else begin
      wr_done      <= 1'b0;
      addr_err     <= 1'b0;
      mem_write_en <= 1'b0;

      // p1: DRAM data_out holds the word addressed one cycle earlier
      vld_p1  <= (state == RD);
      last_p1 <= (state == RD) && (cnt == '0);

      // p2: captured word presented to the core
      resp_valid <= vld_p1;
      resp_last  <= last_p1;
      if (vld_p1) resp_rdata <= mem_data_out;

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (bound_err) begin
              addr_err <= 1'b1;
            end else if (req_write) begin
              state       <= WR;
              wdata_ready <= 1'b1;
            end else begin
              state    <= RD;
              mem_addr <= req_addr;
            end
          end
        end
        RD: begin
          if (cnt == '0) state <= RD_WAIT;
          else           mem_addr <= mem_addr + ADDR_W'(1);
        end
        RD_WAIT: begin
          if (resp_last) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WR: begin
          if (wbeat) begin
            mem_write_en <= 1'b1;
            mem_addr     <= wr_addr;
            mem_data_in  <= wdata;
            if (cnt == '0) begin
              wdata_ready <= 1'b0;
              wr_done     <= 1'b1;
              state       <= WR_END;
            end
          end
        end
        WR_END: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_master.sv
// Bench for dram_port_master: behavioural registered DRAM plus a response scoreboard fed at request time.
module tb_dram_port_master;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int LEN_W     = 4;
  localparam int MEM_DEPTH = 1025;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              resp_valid;
  logic              resp_last;
  logic [DATA_W-1:0] resp_rdata;
  logic              wr_done;
  logic              addr_err;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  logic [DATA_W-1:0] ram     [0:65535];
  logic [DATA_W-1:0] exp_mem [0:65535];
  logic [DATA_W:0]   sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dram_port_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .resp_valid(resp_valid), .resp_last(resp_last), .resp_rdata(resp_rdata),
    .wr_done(wr_done), .addr_err(addr_err),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'hC3A5;
  end

  // Registered DRAM port: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_data_in;
    mem_data_out <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: req_ready=%b required 1", name, req_ready);
    end
  endtask

  task automatic do_load(input string name, input logic [15:0] a, input int len);
    logic [15:0] ea;
    logic [16:0] e;
    wait_ready(name);
    for (int i = 0; i <= len; i++) begin
      ea = a + 16'(i);
      sb_q.push_back({(i == len), exp_mem[ea]});
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = 4'(len);
    tick();
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= len + 4; cyc++) begin
      if (cyc <= len + 1) begin
        ea = a + 16'(cyc - 1);
        n_tests++;
        if (mem_write_en !== 1'b0 || mem_addr !== ea) begin
          n_fail++;
          $display("FAIL %s_addr c%0d: we=%b addr=%h required we=0 addr=%h", name, cyc, mem_write_en, mem_addr, ea);
        end
      end
      n_tests++;
      if (resp_valid !== (cyc >= 3 && cyc <= len + 3)) begin
        n_fail++;
        $display("FAIL %s_rvalid c%0d: resp_valid=%b required %b", name, cyc, resp_valid, (cyc >= 3 && cyc <= len + 3));
      end
      if (resp_valid === 1'b1) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra c%0d: resp_valid=1 required no response", name, cyc);
        end else begin
          e = sb_q.pop_front();
          if (resp_rdata !== e[15:0] || resp_last !== e[16]) begin
            n_fail++;
            $display("FAIL %s_rdata c%0d: data=%h last=%b required data=%h last=%b", name, cyc, resp_rdata, resp_last, e[15:0], e[16]);
          end
        end
      end
      if (cyc == len + 4) begin
        n_tests++;
        if (req_ready !== 1'b1 || sb_q.size() != 0) begin
          n_fail++;
          $display("FAIL %s_done: req_ready=%b pending=%0d required 1 and 0", name, req_ready, sb_q.size());
        end
      end else begin
        tick();
      end
    end
    sb_q.delete();
  endtask

  task automatic do_store(input string name, input logic [15:0] a, input int len,
                          input logic [15:0] d0, input int stall_after);
    int beat = 0;
    int we_cnt = 0;
    bit exp_we = 1'b0, exp_last = 1'b0, stalled = 1'b0, after_done = 1'b0, done = 1'b0, drive_v;
    logic [15:0] exp_a = '0, exp_d = '0;
    wait_ready(name);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = 4'(len);
    tick();
    req_valid = 1'b0;
    for (int cyc = 1; cyc < len + 12 && !done; cyc++) begin
      if (after_done) begin
        n_tests++;
        if (req_ready !== 1'b1 || mem_write_en !== 1'b0 || wr_done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_idle: ready=%b we=%b wr_done=%b required 1 0 0", name, req_ready, mem_write_en, wr_done);
        end
        done = 1'b1;
      end else begin
        n_tests++;
        if (mem_write_en !== exp_we || wr_done !== (exp_we && exp_last) || addr_err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_we c%0d: we=%b wr_done=%b addr_err=%b required %b %b 0", name, cyc, mem_write_en, wr_done, addr_err, exp_we, exp_we && exp_last);
        end
        if (exp_we) begin
          we_cnt++;
          n_tests++;
          if (mem_addr !== exp_a || mem_data_in !== exp_d) begin
            n_fail++;
            $display("FAIL %s_wbeat c%0d: addr=%h data=%h required %h %h", name, cyc, mem_addr, mem_data_in, exp_a, exp_d);
          end
        end
        after_done = exp_we && exp_last;
        n_tests++;
        if (wdata_ready !== (beat <= len)) begin
          n_fail++;
          $display("FAIL %s_wready c%0d: wdata_ready=%b required %b", name, cyc, wdata_ready, (beat <= len));
        end
        drive_v = (beat <= len);
        if (drive_v && stall_after >= 0 && beat == stall_after + 1 && !stalled) begin
          stalled = 1'b1;
          drive_v = 1'b0;
        end
        wdata_valid = drive_v;
        wdata = d0 + 16'(beat);
        exp_we = drive_v;
        exp_a = a + 16'(beat);
        exp_d = d0 + 16'(beat);
        exp_last = (beat == len);
        if (drive_v) begin
          exp_mem[exp_a] = exp_d;
          beat++;
        end
        tick();
        wdata_valid = 1'b0;
      end
    end
    n_tests++;
    if (!done || we_cnt != len + 1) begin
      n_fail++;
      $display("FAIL %s_complete: done=%b writes=%0d required 1 and %0d", name, done, we_cnt, len + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040; req_len = 4'd0;
    wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (req_ready !== 1'b0 || mem_write_en !== 1'b0 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: ready=%b we=%b rvalid=%b required 0 0 0", i, req_ready, mem_write_en, resp_valid);
      end
    end
    rst_n = 1'b1; req_valid = 1'b0;
    tick();
    n_tests++;
    if (req_ready !== 1'b1 || wdata_ready !== 1'b0 || wr_done !== 1'b0 || addr_err !== 1'b0 ||
        resp_last !== 1'b0 || mem_addr !== 16'h0 || mem_data_in !== 16'h0 || resp_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b wrdy=%b wr_done=%b aerr=%b last=%b addr=%h din=%h rdata=%h required 1 0 0 0 0 0000 0000 0000",
               req_ready, wdata_ready, wr_done, addr_err, resp_last, mem_addr, mem_data_in, resp_rdata);
    end
  endtask

  task automatic test_single();
    do_store("single_wr", 16'h0010, 0, 16'h0055, -1);
    do_load("single_rd", 16'h0010, 0);
  endtask

  task automatic test_burst_stall();
    do_store("burst_wr", 16'h0020, 3, 16'h00A0, 1);
    do_load("burst_rd", 16'h0020, 3);
  endtask

  task automatic test_wrap();
`ifndef ADDR_BOUND_CHECK_EN
    do_load("wrap_rd", 16'hFFFE, 3);
`else
    do_load("inrange_rd", 16'h03F0, 3);
`endif
  endtask

  task automatic test_back_to_back();
    do_store("b2b_wr", 16'h0200, 15, 16'h1230, -1);
    do_load("b2b_rd0", 16'h0200, 15);
    do_load("b2b_rd1", 16'h0205, 1);
  endtask

  task automatic test_reset_mid_burst();
    wait_ready("rst_mid");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100; req_len = 4'd7;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_in: ready=%b rvalid=%b required 0 0", req_ready, resp_valid);
    end
    tick();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_rvalid c%0d: resp_valid=%b required 0", i, resp_valid);
      end
      tick();
    end
  endtask

  task automatic test_bound();
`ifdef ADDR_BOUND_CHECK_EN
    wait_ready("bound");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h03FE; req_len = 4'd3;
    wdata_valid = 1'b1; wdata = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (addr_err !== 1'b1 || wdata_ready !== 1'b0 || mem_write_en !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bound_c1: aerr=%b wrdy=%b we=%b ready=%b required 1 0 0 0", addr_err, wdata_ready, mem_write_en, req_ready);
    end
    tick();
    n_tests++;
    if (req_ready !== 1'b1 || addr_err !== 1'b0 || wdata_ready !== 1'b0 || mem_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bound_c2: ready=%b aerr=%b wrdy=%b we=%b required 1 0 0 0", req_ready, addr_err, wdata_ready, mem_write_en);
    end
    wdata_valid = 1'b0;
    tick();
    n_tests++;
    if (mem_write_en !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bound_c3: we=%b rvalid=%b required 0 0", mem_write_en, resp_valid);
    end
`else
    do_store("nobound_wr", 16'h03FE, 3, 16'h7700, -1);
    do_load("nobound_rd", 16'h03FE, 3);
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) exp_mem[i] = 16'(i) ^ 16'hC3A5;
    test_reset();
    test_single();
    test_burst_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_bound();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
